vga_sync_decoder: RTL and testbench

Receive-side counterpart of the VGA timing generator. It samples an incoming hsync/vsync/RGB stream, once per pixel strobe, and recovers pixel coordinates and a data-enable. It checks line and frame lengths against the 640x480@60 timing and reports lock. It sits on the board-level or bench loopback path so that generated video can be captured, checked and, optionally, CRC'd per frame.

---
 rtl/vga_sync_decoder.sv | 173 +++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA receive-side sync decoder with lock tracking; optional per-frame CRC via VGA_DEC_CRC_EN
module vga_sync_decoder #(
  parameter int H_TOTAL  = 800,
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb_in,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic        de_out,
  output logic [11:0] rgb_out,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [9:0]  line_len
`ifdef VGA_DEC_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`endif
);

  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [9:0]  H_LO      = 10'(H_START);
  localparam logic [9:0]  H_HI      = 10'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_LO      = 10'(V_START);
  localparam logic [9:0]  V_HI      = 10'(V_START + V_ACTIVE);
  localparam logic [9:0]  POS_MAX   = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state, state_next;
  logic        s1_hs, s1_vs, s2_hs, s2_vs;
  logic [11:0] s1_rgb, s2_rgb;
  logic [9:0]  h_pos, v_pos;
  logic        vpend;
  logic        h_fall, v_fall, fs_evt;
  logic        line_bad_evt, frame_bad_evt;
  logic        active, err_next;
  logic [10:0] len_next, frame_len_next;

  assign h_fall         = s2_hs & ~s1_hs;
  assign v_fall         = s2_vs & ~s1_vs;
  assign fs_evt         = pix_en & h_fall & (vpend | v_fall);
  assign len_next       = {1'b0, h_pos} + 11'd1;
  assign frame_len_next = {1'b0, v_pos} + 11'd1;

  // Reaching saturation is flagged immediately so a dead hsync still drops lock.
  assign line_bad_evt  = pix_en & ((h_fall & (len_next != H_TOTAL_W)) |
                                   (~h_fall & (h_pos == POS_MAX - 10'd1)));
  assign frame_bad_evt = fs_evt & (frame_len_next != V_TOTAL_W);

  assign active = (h_pos >= H_LO) && (h_pos < H_HI) && (v_pos >= V_LO) && (v_pos < V_HI);

  always_ff @(posedge clk) begin
    if (rst) state <= SEARCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SEARCH:  if (fs_evt) state_next = ACQUIRE;
      ACQUIRE: begin
        if (line_bad_evt || frame_bad_evt) state_next = SEARCH;
        else if (fs_evt)                   state_next = LOCKED;
      end
      LOCKED:  if (line_bad_evt || frame_bad_evt) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    locked   = (state == LOCKED);
    err_next = (state == LOCKED) && (state_next == SEARCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s2_hs       <= 1'b1;
      s2_vs       <= 1'b1;
      s1_rgb      <= '0;
      s2_rgb      <= '0;
      h_pos       <= '0;
      v_pos       <= '0;
      vpend       <= 1'b0;
      line_len    <= '0;
      frame_start <= 1'b0;
      err         <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      de_out      <= 1'b0;
      rgb_out     <= '0;
    end else begin
      frame_start <= 1'b0;
      err         <= err_next;
      if (pix_en) begin
        s1_hs  <= hsync;
        s1_vs  <= vsync;
        s1_rgb <= rgb_in;
        s2_hs  <= s1_hs;
        s2_vs  <= s1_vs;
        s2_rgb <= s1_rgb;
        if (h_fall) begin
          h_pos    <= '0;
          line_len <= len_next[9:0];
          // A vsync edge coincident with hsync is consumed on this same line start.
          if (vpend || v_fall) begin
            v_pos       <= '0;
            vpend       <= 1'b0;
            frame_start <= 1'b1;
          end else if (v_pos != POS_MAX) begin
            v_pos <= v_pos + 10'd1;
          end
        end else begin
          if (h_pos != POS_MAX) h_pos <= h_pos + 10'd1;
          if (v_fall) vpend <= 1'b1;
        end
        rgb_out <= s2_rgb;
        de_out  <= locked & active;
        if (active) begin
          x_out <= h_pos - H_LO;
          y_out <= v_pos - V_LO;
        end
      end
    end
  end

`ifdef VGA_DEC_CRC_EN
  logic [15:0] crc_acc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    logic [15:0] w;
    r = c;
    w = {4'b0000, d};
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ w[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_acc   <= 16'hFFFF;
      frame_crc <= '0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if (fs_evt) begin
        frame_crc <= crc_acc;
        crc_valid <= 1'b1;
        crc_acc   <= 16'hFFFF;
      end else if (pix_en && locked && active) begin
        crc_acc <= crc_step(crc_acc, s2_rgb);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed self-checking bench for vga_sync_decoder on a reduced timing
module tb_vga_sync_decoder;

  localparam int HT = 20;
  localparam int HS = 4;
  localparam int HA = 12;
  localparam int VT = 12;
  localparam int VS = 3;
  localparam int VA = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb_in;
  logic [9:0]  x_out;
  logic [9:0]  y_out;
  logic        de_out;
  logic [11:0] rgb_out;
  logic        frame_start;
  logic        locked;
  logic        err;
  logic [9:0]  line_len;
`ifdef VGA_DEC_CRC_EN
  logic [15:0] frame_crc;
  logic        crc_valid;
`endif

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .rgb_in(rgb_in), .x_out(x_out), .y_out(y_out), .de_out(de_out),
    .rgb_out(rgb_out), .frame_start(frame_start), .locked(locked),
    .err(err), .line_len(line_len)
`ifdef VGA_DEC_CRC_EN
    , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fs_cnt, err_cnt, de_cnt, align_bad, crc_cnt, err_len;
  logic [9:0] first_x, first_y, last_x, last_y;
  bit const_rgb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    fs_cnt = 0; err_cnt = 0; de_cnt = 0; align_bad = 0; crc_cnt = 0; err_len = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_start) fs_cnt++;
    if (err) begin
      err_cnt++;
      err_len = int'(line_len);
    end
`ifdef VGA_DEC_CRC_EN
    if (crc_valid) crc_cnt++;
`endif
  endtask

  task automatic strobe(input logic hs, input logic vs, input logic [11:0] rgb);
    logic [9:0]  tx, ty;
    logic [11:0] exp_rgb;
    hsync = hs; vsync = vs; rgb_in = rgb; pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    if (de_out) begin
      de_cnt++;
      if (de_cnt == 1) begin first_x = x_out; first_y = y_out; end
      last_x = x_out; last_y = y_out;
      tx = x_out + 10'(HS);
      ty = y_out + 10'(VS);
      exp_rgb = const_rgb ? 12'hFFF : {tx[5:0], ty[5:0]};
      if (rgb_out !== exp_rgb) align_bad++;
    end
    tick();
  endtask

  task automatic send_line(input int vc, input int len);
    logic [11:0] px;
    for (int hc = 0; hc < len; hc++) begin
      px = const_rgb ? 12'hFFF : {hc[5:0], vc[5:0]};
      strobe((hc < 3) ? 1'b0 : 1'b1, (vc < 2) ? 1'b0 : 1'b1, px);
    end
  endtask

  task automatic send_frame(input int nlines, input int long_line);
    for (int vc = 0; vc < nlines; vc++) send_line(vc, (vc == long_line) ? HT + 1 : HT);
  endtask

`ifdef VGA_DEC_CRC_EN
  function automatic logic [15:0] model_crc(input int n);
    logic [15:0] r;
    logic [15:0] w;
    r = 16'hFFFF;
    w = 16'h0FFF;
    for (int k = 0; k < n; k++)
      for (int i = 15; i >= 0; i--)
        r = (r[15] ^ w[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction
`endif

  initial begin
    rst = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb_in = '0; const_rgb = 1'b0;
    clear_counts();
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      hsync = i[0]; vsync = i[1]; rgb_in = 12'hABC; pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      tick(); tick(); tick();
    end
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_de", de_out, 0);
    check("rst_rgb", rgb_out, 0);
    check("rst_fs", frame_start, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_line_len", line_len, 0);

    rst = 1'b0; hsync = 1'b1; vsync = 1'b1;
    tick();

    clear_counts(); send_frame(VT, -1);
    check("f1_fs", fs_cnt, 1);
    check("f1_locked", locked, 0);
    check("f1_de", de_cnt, 0);

    clear_counts(); send_frame(VT, -1);
    check("f2_locked", locked, 1);
    check("f2_fs", fs_cnt, 1);
    check("f2_de_count", de_cnt, HA * VA);
    check("f2_first_x", first_x, 0);
    check("f2_first_y", first_y, 0);
    check("f2_last_x", last_x, HA - 1);
    check("f2_last_y", last_y, VA - 1);
    check("f2_align", align_bad, 0);
    check("f2_line_len", line_len, HT);

    clear_counts(); send_frame(VT, -1);
    check("f3_de_count", de_cnt, HA * VA);
    check("f3_locked", locked, 1);
    check("f3_err", err_cnt, 0);

    clear_counts(); send_frame(VT, 5);
    check("long_err_cnt", err_cnt, 1);
    check("long_line_len", err_len, HT + 1);
    check("long_locked", locked, 0);

    clear_counts(); send_frame(VT, -1);
    check("relock1_locked", locked, 0);
    clear_counts(); send_frame(VT, -1);
    check("relock2_locked", locked, 1);
    check("relock2_err", err_cnt, 0);

    clear_counts(); send_frame(3, -1);
    check("mid_locked", locked, 1);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("mid_rst_locked", locked, 0);
    check("mid_rst_line_len", line_len, 0);

    clear_counts(); send_frame(VT - 1, -1);
    check("short_acq_locked", locked, 0);
    clear_counts(); send_frame(VT, -1);
    check("short_no_err", err_cnt, 0);
    check("short_locked", locked, 0);
    clear_counts(); send_frame(VT, -1);
    check("short_after1", locked, 0);
    clear_counts(); send_frame(VT, -1);
    check("short_after2", locked, 1);

`ifdef VGA_DEC_CRC_EN
    const_rgb = 1'b1;
    clear_counts(); send_frame(VT, -1);
    clear_counts(); send_frame(VT, -1);
    check("crc_value", frame_crc, model_crc(HA * VA));
    check("crc_valid_cnt", crc_cnt, 1);
    const_rgb = 1'b0;
`endif

    clear_counts();
    for (int i = 0; i < 1100; i++) strobe(1'b1, 1'b1, 12'h000);
    check("stuck_h_pos", dut.h_pos, 1023);
    check("stuck_err", err_cnt, 1);
    check("stuck_locked", locked, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
